// File: rtl/enemies_formation_move.sv
// Enemy formation mover: horizontal sweep with edge bounce and step-down, alive mask, pixel hit test.
// Optional build macro SPEEDUP_EN: speed grows with the number of killed enemies.
module enemies_formation_move #(
    parameter int unsigned COLS            = 6,
    parameter int unsigned ROWS            = 3,
    parameter int unsigned INITIAL_X       = 64,
    parameter int unsigned INITIAL_Y       = 40,
    parameter int unsigned OBJECT_WIDTH_X  = 30,
    parameter int unsigned OBJECT_HEIGHT_Y = 30,
    parameter int unsigned GAP_X           = 10,
    parameter int unsigned GAP_Y           = 10,
    parameter int unsigned X_SPEED         = 120,
    parameter int unsigned STEP_Y          = 16,
    parameter int unsigned SCREEN_W        = 640,
    parameter int unsigned BOTTOM_LIMIT    = 400,
    parameter int unsigned DIR_CHANGE_WAIT = 100,
    parameter int unsigned SPEEDUP_STEP    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    input  logic                   changeDirection,
    input  logic                   killValid,
    input  logic [7:0]             killIndex,
    output logic [10:0]            topLeftX,
    output logic [10:0]            topLeftY,
    output logic [10:0]            offsetX,
    output logic [10:0]            offsetY,
    output logic                   drawingRequest,
    output logic [7:0]             enemyIndex,
    output logic [COLS*ROWS-1:0]   aliveMask,
    output logic                   allDead,
    output logic                   reachedBottom
);

    localparam int unsigned N       = COLS * ROWS;
    localparam int unsigned PITCH_X = OBJECT_WIDTH_X + GAP_X;
    localparam int unsigned PITCH_Y = OBJECT_HEIGHT_Y + GAP_Y;
    localparam int unsigned CW      = 4;
    localparam int unsigned RW      = 3;
    localparam int unsigned TW      = 16;

    typedef enum logic [1:0] {RUN, DESCEND, LANDED, CLEARED} state_t;

    state_t               state, state_n;
    logic signed [31:0]   pos_x, pos_x_n, pos_y, pos_y_n;
    logic                 dir_neg, dir_n;
    logic [TW-1:0]        timer, timer_n;
    logic [TW-1:0]        step_cnt, step_n;

    logic signed [31:0]   tl_x, tl_y;
    logic signed [31:0]   speed, nx, ny;
    logic signed [31:0]   left_edge, right_edge, bottom_edge;
    logic                 bounce, landed;

    logic [COLS-1:0]      col_alive;
    logic [ROWS-1:0]      row_alive;
    logic [CW-1:0]        left_col, right_col;
    logic [RW-1:0]        bottom_row;
    logic [N-1:0]         kill_onehot;

    // Signed division truncates toward zero, matching position/64
    assign tl_x     = pos_x / 32'sd64;
    assign tl_y     = pos_y / 32'sd64;
    assign topLeftX = 11'(tl_x);
    assign topLeftY = 11'(tl_y);

`ifdef SPEEDUP_EN
    logic [7:0] alive_cnt;
    always_comb begin
        alive_cnt = '0;
        for (int i = 0; i < N; i++) alive_cnt = alive_cnt + 8'(aliveMask[i]);
    end
    assign speed = 32'(X_SPEED) + 32'(SPEEDUP_STEP) * (32'(N) - 32'(alive_cnt));
`else
    assign speed = 32'(X_SPEED);
`endif

    // Bounding box of the alive enemies
    always_comb begin
        col_alive  = '0;
        row_alive  = '0;
        left_col   = '0;
        right_col  = '0;
        bottom_row = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (aliveMask[r*COLS + c]) begin
                    col_alive[c] = 1'b1;
                    row_alive[r] = 1'b1;
                end
        for (int c = COLS - 1; c >= 0; c--) if (col_alive[c]) left_col = CW'(c);
        for (int c = 0; c < COLS; c++) if (col_alive[c]) right_col = CW'(c);
        for (int r = 0; r < ROWS; r++) if (row_alive[r]) bottom_row = RW'(r);
    end

    always_comb begin
        nx          = dir_neg ? pos_x - speed : pos_x + speed;
        ny          = pos_y + 32'sd64;
        left_edge   = nx + $signed(32'(left_col) * 32'(PITCH_X * 64));
        right_edge  = nx + $signed(32'(right_col) * 32'(PITCH_X * 64) + 32'(OBJECT_WIDTH_X * 64));
        bottom_edge = ny + $signed(32'(bottom_row) * 32'(PITCH_Y * 64) + 32'(OBJECT_HEIGHT_Y * 64));
        bounce      = (left_edge < 0) || (right_edge > $signed(32'(SCREEN_W * 64)));
        landed      = bottom_edge >= $signed(32'(BOTTOM_LIMIT * 64));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            pos_x    <= $signed(32'(INITIAL_X * 64));
            pos_y    <= $signed(32'(INITIAL_Y * 64));
            dir_neg  <= 1'b0;
            timer    <= '0;
            step_cnt <= '0;
        end else begin
            state    <= state_n;
            pos_x    <= pos_x_n;
            pos_y    <= pos_y_n;
            dir_neg  <= dir_n;
            timer    <= timer_n;
            step_cnt <= step_n;
        end
    end

    always_comb begin
        state_n = state;
        pos_x_n = pos_x;
        pos_y_n = pos_y;
        dir_n   = dir_neg;
        timer_n = timer;
        step_n  = step_cnt;
        if (startOfFrame && timer != '0) timer_n = timer - TW'(1);
        case (state)
            RUN: begin
                if (startOfFrame) begin
                    if (bounce) begin
                        dir_n   = ~dir_neg;
                        step_n  = TW'(STEP_Y);
                        state_n = DESCEND;
                    end else begin
                        pos_x_n = nx;
                    end
                end
                // A same-cycle bounce already reversed the direction, so the request is dropped
                if (changeDirection && timer == '0 && !(startOfFrame && bounce)) begin
                    dir_n   = ~dir_neg;
                    timer_n = TW'(DIR_CHANGE_WAIT);
                end
            end
            DESCEND: begin
                if (startOfFrame) begin
                    pos_y_n = ny;
                    step_n  = step_cnt - TW'(1);
                    if (landed)
                        state_n = LANDED;
                    else if (step_cnt <= TW'(1))
                        state_n = RUN;
                end
            end
            default: ;
        endcase
        if (aliveMask == '0 && state != LANDED) state_n = CLEARED;
    end

    always_comb begin
        kill_onehot = '0;
        for (int i = 0; i < N; i++)
            if (killValid && killIndex == 8'(i)) kill_onehot[i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) aliveMask <= '1;
        else       aliveMask <= aliveMask & ~kill_onehot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            allDead       <= 1'b0;
            reachedBottom <= 1'b0;
        end else begin
            allDead       <= (state_n == CLEARED);
            reachedBottom <= (state_n == LANDED);
        end
    end

    // Pixel hit test against the current formation position
    logic signed [31:0] dx, dy;
    logic [31:0]        col_q, col_r, row_q, row_r, hit_idx;
    logic [N-1:0]       alive_sh;
    logic               hit;

    always_comb begin
        dx       = $signed({21'b0, pixelX}) - tl_x;
        dy       = $signed({21'b0, pixelY}) - tl_y;
        col_q    = '0;
        col_r    = '0;
        row_q    = '0;
        row_r    = '0;
        hit_idx  = '0;
        alive_sh = '0;
        hit      = 1'b0;
        if (dx >= 0 && dy >= 0) begin
            col_q    = $unsigned(dx) / PITCH_X;
            col_r    = $unsigned(dx) % PITCH_X;
            row_q    = $unsigned(dy) / PITCH_Y;
            row_r    = $unsigned(dy) % PITCH_Y;
            hit_idx  = row_q * COLS + col_q;
            alive_sh = aliveMask >> hit_idx;
            hit      = (col_q < COLS) && (row_q < ROWS) &&
                       (col_r < OBJECT_WIDTH_X) && (row_r < OBJECT_HEIGHT_Y) && alive_sh[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !hit || state == CLEARED) begin
            drawingRequest <= 1'b0;
            offsetX        <= '0;
            offsetY        <= '0;
            enemyIndex     <= '0;
        end else begin
            drawingRequest <= 1'b1;
            offsetX        <= 11'(col_r);
            offsetY        <= 11'(row_r);
            enemyIndex     <= 8'(hit_idx);
        end
    end

endmodule

// File: tb/tb_enemies_formation_move.sv
// Directed self-checking bench for enemies_formation_move with default parameters.
module tb_enemies_formation_move;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic [10:0] pixelX, pixelY;
    logic        changeDirection;
    logic        killValid;
    logic [7:0]  killIndex;
    logic [10:0] topLeftX, topLeftY, offsetX, offsetY;
    logic        drawingRequest;
    logic [7:0]  enemyIndex;
    logic [17:0] aliveMask;
    logic        allDead, reachedBottom;

    int n_checks = 0;
    int n_errors = 0;

    enemies_formation_move dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .changeDirection(changeDirection),
        .killValid      (killValid),
        .killIndex      (killIndex),
        .topLeftX       (topLeftX),
        .topLeftY       (topLeftY),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .drawingRequest (drawingRequest),
        .enemyIndex     (enemyIndex),
        .aliveMask      (aliveMask),
        .allDead        (allDead),
        .reachedBottom  (reachedBottom)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            startOfFrame = 1'b1;
            @(negedge clk);
            startOfFrame = 1'b0;
        end
    endtask

    task automatic change_dir(input logic with_frame);
        @(negedge clk);
        changeDirection = 1'b1;
        startOfFrame    = with_frame;
        @(negedge clk);
        changeDirection = 1'b0;
        startOfFrame    = 1'b0;
    endtask

    task automatic kill(input int idx);
        @(negedge clk);
        killValid = 1'b1;
        killIndex = 8'(idx);
        @(negedge clk);
        killValid = 1'b0;
    endtask

    task automatic probe(input int px, input int py);
        @(negedge clk);
        pixelX = 11'(px);
        pixelY = 11'(py);
        @(negedge clk);
    endtask

    task automatic check_pix(input string tag, input logic dr, input int idx, input int ox, input int oy);
        check({tag, "_dr"},  32'(drawingRequest), 32'(dr));
        check({tag, "_idx"}, 32'(enemyIndex),     32'(idx));
        check({tag, "_ox"},  32'(offsetX),        32'(ox));
        check({tag, "_oy"},  32'(offsetY),        32'(oy));
    endtask

    initial begin
        reset = 1'b0; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
        changeDirection = 1'b0; killValid = 1'b0; killIndex = '0;

        // Reset state
        do_reset();
        check("rst_x",    32'(topLeftX), 64);
        check("rst_y",    32'(topLeftY), 40);
        check("rst_mask", 32'(aliveMask), 32'h3FFFF);
        check_pix("rst_pix", 1'b0, 0, 0, 0);
        check("rst_dead", 32'(allDead), 0);
        check("rst_bot",  32'(reachedBottom), 0);

        // Pixel hit test at the reset position (64,40)
        probe(109, 81);  check_pix("pix_e7",   1'b1, 7, 5, 1);
        probe(93, 69);   check_pix("pix_e0c",  1'b1, 0, 29, 29);
        probe(264, 120); check_pix("pix_e17",  1'b1, 17, 0, 0);
        probe(63, 81);   check_pix("pix_left", 1'b0, 0, 0, 0);
        probe(94, 40);   check_pix("pix_gap",  1'b0, 0, 0, 0);
        probe(304, 40);  check_pix("pix_col6", 1'b0, 0, 0, 0);
        probe(64, 160);  check_pix("pix_row3", 1'b0, 0, 0, 0);

        frames(10);
        check("f10_x", 32'(topLeftX), 82);
        check("f10_y", 32'(topLeftY), 40);

        // Right-edge bounce and 16-frame descent
        do_reset();
        frames(184);
        check("b184_x", 32'(topLeftX), 409);
        frames(1);
        check("bnc_x", 32'(topLeftX), 409);
        check("bnc_y", 32'(topLeftY), 40);
        frames(8);
        check("d8_y", 32'(topLeftY), 48);
        check("d8_x", 32'(topLeftX), 409);
        frames(8);
        check("d16_y", 32'(topLeftY), 56);
        frames(1);
        check("run_x", 32'(topLeftX), 407);
        check("run_y", 32'(topLeftY), 56);

        // Bounce wins over a same-cycle changeDirection; timer stays free
        do_reset();
        frames(184);
        change_dir(1'b1);
        check("bw_x", 32'(topLeftX), 409);
        frames(16);
        check("bw_y", 32'(topLeftY), 56);
        change_dir(1'b0);
        frames(1);
        check("bw_rebounce_x", 32'(topLeftX), 409);
        frames(1);
        check("bw_rebounce_y", 32'(topLeftY), 57);

        // changeDirection with cooldown
        do_reset();
        frames(150);
        check("cd_start_x", 32'(topLeftX), 345);
        change_dir(1'b0);
        frames(1);
        check("cd_flip_x", 32'(topLeftX), 343);
        frames(4);
        check("cd_f5_x", 32'(topLeftX), 335);
        change_dir(1'b0);
        frames(1);
        check("cd_ign_x", 32'(topLeftX), 334);
        frames(93);
        check("cd_f99_x", 32'(topLeftX), 159);
        change_dir(1'b0);
        frames(1);
        check("cd_t1_ign_x", 32'(topLeftX), 157);
        change_dir(1'b0);
        frames(1);
        check("cd_again_x", 32'(topLeftX), 159);

        // Kill column 5; invalid and repeated kills are ignored
        do_reset();
        kill(5); kill(11); kill(17);
        kill(18); kill(200); kill(5);
        check("k5_mask", 32'(aliveMask), 32'h1F7DF);
        probe(266, 42); check_pix("k5_dead", 1'b0, 0, 0, 0);
        probe(226, 42); check_pix("k5_live", 1'b1, 4, 2, 2);
        frames(205);
        check("k5_f205_x", 32'(topLeftX), 448);
        frames(1);
        check("k5_bnc_x", 32'(topLeftX), 448);
        check("k5_bnc_y", 32'(topLeftY), 40);
        frames(1);
        check("k5_desc_y", 32'(topLeftY), 41);

        // Kill everything: allDead one cycle after the mask empties, then frozen
        do_reset();
        for (int i = 0; i < 17; i++) kill(i);
        check("ka_mask17", 32'(aliveMask), 32'h20000);
        check("ka_dead_pre", 32'(allDead), 0);
        kill(17);
        check("ka_mask0", 32'(aliveMask), 0);
        check("ka_dead_0", 32'(allDead), 0);
        @(negedge clk);
        check("ka_dead_1", 32'(allDead), 1);
        check("ka_bot", 32'(reachedBottom), 0);
        probe(109, 81); check_pix("ka_pix", 1'b0, 0, 0, 0);
        frames(1);
        check("ka_frozen_x", 32'(topLeftX), 64);

        // Reset in the middle of a descent
        do_reset();
        frames(190);
        check("md_y", 32'(topLeftY), 45);
        do_reset();
        check("md_rst_x", 32'(topLeftX), 64);
        check("md_rst_y", 32'(topLeftY), 40);
        check("md_rst_mask", 32'(aliveMask), 32'h3FFFF);
        frames(1);
        check("md_run_x", 32'(topLeftX), 65);
        check("md_run_y", 32'(topLeftY), 40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
